// File: rtl/rom_fetch_unit_pkg.sv
// Shared definitions for the ROM fetch unit: bus widths, FSM state encoding
// and the sizing helper for the ROM settle counter.
package rom_fetch_unit_pkg;

   localparam int ROM_ADDR_W = 5;
   localparam int ROM_DATA_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } fetch_state_t;

   // A zero-wait configuration still needs a 1-bit counter to stay legal.
   function automatic int wait_cnt_width(input int wait_cycles);
      return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/rom_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, word} between the ROM reader and the decode stage.
// Flush wins over push and pop; an empty queue presents an all-zero head.
module fetch_queue
   import rom_fetch_unit_pkg::*;
#(
   parameter int WIDTH = ROM_ADDR_W + ROM_DATA_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] entries [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             pop_en;
   logic             push_en;

   // A full queue only accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop_en  = pop && (count != 2'd0);
      push_en = push && ((count < 2'd2) || pop_en);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entries[0] <= '0;
         entries[1] <= '0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_en) begin
            entries[wr_ptr] <= push_entry;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop_en) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = (count != 2'd0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction fetch initiator: walks a PC over the ROM bus, samples each word
// after the settle time and hands {pc, word} to decode through a 2-entry queue.
module rom_fetch_unit
   import rom_fetch_unit_pkg::*;
#(
   parameter int ADDR_W      = ROM_ADDR_W,
   parameter int DATA_W      = ROM_DATA_W,
   parameter int WAIT_CYCLES = 0,
   parameter int RESET_PC    = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_cs,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int             WCW       = wait_cnt_width(WAIT_CYCLES);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);

   fetch_state_t             state;
   fetch_state_t             next_state;
   logic [WCW-1:0]           wait_cnt;
   logic [ADDR_W-1:0]        fetch_pc;
   logic [ADDR_W-1:0]        pc_next;
   logic [1:0]               count;
   logic [2:0]               count_after;
   logic                     sample_done;
   logic                     push;
   logic                     pop;
   logic                     start_read;
   logic [ADDR_W+DATA_W-1:0] head;

   // Another read may only start if its word is guaranteed a queue slot when
   // it completes, so the occupancy after this cycle's push/pop is what counts.
   always_comb begin
      sample_done = (state == READ) && (wait_cnt == '0);
      push        = sample_done && !redirect;
      pop         = instr_valid && instr_ready && !redirect;
      count_after = {1'b0, count} + {2'b00, push} - {2'b00, pop};

      pc_next = fetch_pc;
      if (redirect) begin
         pc_next = redirect_addr;
      end else if (push) begin
         pc_next = fetch_pc + ADDR_W'(1);
      end

      next_state = state;
      start_read = 1'b0;
      if (redirect) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (enable && ((count < 2'd2) || pop)) begin
                  next_state = READ;
                  start_read = 1'b1;
               end
            end
            READ: begin
               if (sample_done) begin
                  if (enable && (count_after < 3'd2)) begin
                     start_read = 1'b1;
                  end else begin
                     next_state = IDLE;
                  end
               end
            end
         endcase
      end
   end

   // ROM bus outputs are registered so the address is stable for the whole read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         fetch_pc    <= ADDR_W'(RESET_PC);
         rom_cs      <= 1'b0;
         rom_address <= '0;
         wait_cnt    <= '0;
      end else begin
         state    <= next_state;
         fetch_pc <= pc_next;
         if (start_read) begin
            rom_cs      <= 1'b1;
            rom_address <= pc_next;
            wait_cnt    <= WAIT_LOAD;
         end else begin
            if (next_state == IDLE) begin
               rom_cs <= 1'b0;
            end
            if ((state == READ) && (wait_cnt != '0)) begin
               wait_cnt <= wait_cnt - WCW'(1);
            end
         end
      end
   end

   fetch_queue #(
      .WIDTH(ADDR_W + DATA_W)
   ) u_queue (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_entry({fetch_pc, rom_data}),
      .pop       (pop),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

   assign instr_valid = (count != 2'd0);
   assign instr_pc    = head[ADDR_W+DATA_W-1 -: ADDR_W];
   assign instr_data  = head[DATA_W-1:0];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: a zero-wait instance and a 2-wait-cycle
// instance, each with a ROM model and a monitor popping expected pcs.
module tb_rom_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int delivered0 = 0;
   int delivered1 = 0;
   int base = 0;

   logic [4:0] expect0 [$];
   logic [4:0] expect1 [$];

   logic        reset0_n, enable0, redirect0, ready0, cs0, valid0;
   logic [4:0]  redirect_addr0, addr0, pc0;
   logic [31:0] rom_data0, data0;

   logic        reset1_n, enable1, redirect1, ready1, cs1, valid1;
   logic [4:0]  redirect_addr1, addr1, pc1;
   logic [31:0] rom_data1, data1;

   function automatic logic [31:0] rom_word(input logic [4:0] a);
      return {27'd0, a} * 32'h01010101;
   endfunction

   // ROM returns garbage while deselected so a stray sample is visible.
   assign rom_data0 = cs0 ? rom_word(addr0) : 32'hDEADBEEF;
   assign rom_data1 = cs1 ? rom_word(addr1) : 32'hDEADBEEF;

   rom_fetch_unit #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0), .RESET_PC(0)) dut0 (
      .clk(clk), .reset_n(reset0_n), .enable(enable0), .rom_address(addr0), .rom_cs(cs0),
      .rom_data(rom_data0), .redirect(redirect0), .redirect_addr(redirect_addr0),
      .instr_valid(valid0), .instr_ready(ready0), .instr_data(data0), .instr_pc(pc0)
   );

   rom_fetch_unit #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(2), .RESET_PC(0)) dut1 (
      .clk(clk), .reset_n(reset1_n), .enable(enable1), .rom_address(addr1), .rom_cs(cs1),
      .rom_data(rom_data1), .redirect(redirect1), .redirect_addr(redirect_addr1),
      .instr_valid(valid1), .instr_ready(ready1), .instr_data(data1), .instr_pc(pc1)
   );

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h required=0x%0h", name, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_expect0(input logic [4:0] start);
      for (int i = 0; i < 40; i++) expect0.push_back(start + 5'(i));
   endtask

   task automatic load_expect1(input logic [4:0] start);
      for (int i = 0; i < 40; i++) expect1.push_back(start + 5'(i));
   endtask

   // Transfers are judged just before the edge that performs them.
   always @(negedge clk) begin
      logic [4:0] e;
      if (reset0_n && !redirect0 && valid0 && ready0) begin
         if (expect0.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL dut0_extra: got pc=%0d required no delivery", pc0);
         end else begin
            e = expect0.pop_front();
            check_output("dut0_deliver", {pc0, data0}, {e, rom_word(e)});
         end
         delivered0++;
      end
   end

   always @(negedge clk) begin
      logic [4:0] e;
      if (reset1_n && !redirect1 && valid1 && ready1) begin
         if (expect1.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL dut1_extra: got pc=%0d required no delivery", pc1);
         end else begin
            e = expect1.pop_front();
            check_output("dut1_deliver", {pc1, data1}, {e, rom_word(e)});
         end
         delivered1++;
      end
   end

   task automatic apply_stimulus();
      reset0_n = 0; enable0 = 1; ready0 = 1; redirect0 = 0; redirect_addr0 = 0;
      reset1_n = 0; enable1 = 1; ready1 = 1; redirect1 = 0; redirect_addr1 = 0;
      #2;
      check_output("reset_cs", {cs0, valid0}, 2'b00);
      check_output("reset_outs", {addr0, pc0, data0}, '0);
      repeat (3) tick();

      // Zero-wait streaming, then a stalled consumer.
      load_expect0(5'd0);
      reset0_n = 1;
      tick();
      check_output("e1_bus", {cs0, addr0, valid0}, {1'b1, 5'd0, 1'b0});
      tick();
      check_output("e2_bus", {cs0, addr0, valid0, pc0}, {1'b1, 5'd1, 1'b1, 5'd0});
      ready0 = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("stall_hold", {cs0, valid0, pc0, data0}, {1'b0, 1'b1, 5'd0, 32'd0});
      end
      ready0 = 1;
      tick();
      check_output("resume_bus", {cs0, addr0}, {1'b1, 5'd2});
      repeat (5) tick();
      check_output("count_pre_redirect", delivered0, 6);

      // Redirect to 30 with wrap.
      redirect0 = 1; redirect_addr0 = 5'd30;
      expect0.delete();
      load_expect0(5'd30);
      tick();
      check_output("redirect_idle", {cs0, valid0}, 2'b00);
      redirect0 = 0;
      tick();
      check_output("redirect_read", {cs0, addr0, valid0}, {1'b1, 5'd30, 1'b0});
      base = delivered0;
      repeat (5) tick();
      check_output("count_post_redirect", delivered0 - base, 4);

      // Enable drop during the read of address 4.
      tick();
      check_output("read_addr4", {cs0, addr0}, {1'b1, 5'd4});
      enable0 = 0;
      tick();
      check_output("disable_done", {cs0, valid0, pc0}, {1'b0, 1'b1, 5'd4});
      tick();
      check_output("disable_idle1", {cs0, valid0}, 2'b00);
      tick();
      check_output("disable_idle2", cs0, 1'b0);
      enable0 = 1;
      tick();
      check_output("resume_addr5", {cs0, addr0}, {1'b1, 5'd5});
      repeat (3) tick();
      check_output("count_enable_phase", delivered0 - base, 9);

      // Async reset in the middle of a read.
      #2;
      reset0_n = 0;
      expect0.delete();
      load_expect0(5'd0);
      #1;
      check_output("async_reset", {cs0, valid0, pc0, data0}, '0);
      tick();
      tick();
      reset0_n = 1;
      tick();
      check_output("restart_bus", {cs0, addr0, valid0}, {1'b1, 5'd0, 1'b0});
      tick();
      check_output("restart_head", {valid0, pc0, data0}, {1'b1, 5'd0, 32'd0});
      base = delivered0;
      repeat (2) tick();
      check_output("count_restart", delivered0 - base, 2);
      ready0 = 0;
      enable0 = 0;

      // Two settle cycles; redirect in the second wait cycle of address 5.
      tick();
      load_expect1(5'd0);
      reset1_n = 1;
      tick();
      check_output("w_e1", {cs1, addr1, valid1}, {1'b1, 5'd0, 1'b0});
      repeat (2) tick();
      check_output("w_e3", {cs1, addr1, valid1}, {1'b1, 5'd0, 1'b0});
      tick();
      check_output("w_e4", {cs1, addr1, valid1, pc1}, {1'b1, 5'd1, 1'b1, 5'd0});
      repeat (12) tick();
      check_output("w_addr5", {cs1, addr1}, {1'b1, 5'd5});
      tick();
      check_output("w_addr5_wait2", {cs1, addr1}, {1'b1, 5'd5});
      check_output("w_count_pre", delivered1, 5);
      redirect1 = 1; redirect_addr1 = 5'd20;
      expect1.delete();
      load_expect1(5'd20);
      tick();
      check_output("w_redirect_idle", {cs1, valid1}, 2'b00);
      redirect1 = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("w_addr20_held", {cs1, addr1}, {1'b1, 5'd20});
      end
      tick();
      check_output("w_after20", {cs1, addr1, valid1, pc1, data1},
                   {1'b1, 5'd21, 1'b1, 5'd20, 32'h14141414});
      base = delivered1;
      repeat (4) tick();
      check_output("w_count_post", delivered1 - base, 2);
   endtask

   initial begin
      apply_stimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
